cdb_age_arbiter: RTL
====================

Name: cdb_age_arbiter

Overview:
- Arbitrates one Common Data Bus (CDB) writeback slot per cycle among NUM_REQ functional-unit result ports: br, mem, div, mul, alu.
- Uses a valid/ready handshake, so FUs hold their result until granted; no unbounded enqueue.
- Base policy is fixed priority. A per-requester wait counter promotes any requester that has waited STARVE_LIMIT cycles, so the alu/mul ports cannot starve.
- Output is registered; the block sits between the FU output stages and the ROB/reservation-station CDB broadcast.

Parameters:
- NUM_REQ, 5, number of requesters. Index 0 has the highest base priority; 0=br, 1=mem, 2=div, 3=mul, 4=alu.
- STARVE_LIMIT, 8, waiting cycles after which a requester becomes starved. Must be ≥1.
- CNT_W, $clog2(STARVE_LIMIT+1), width of each wait counter.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- flush  in  1  synchronous pipeline flush
- cdb_stall  in  1  consumer backpressure; no grant while high
- req_valid  in  NUM_REQ  per-requester result valid
- req_data  in  cdb_t[NUM_REQ]  per-requester result payload
- req_ready  out  NUM_REQ  one-hot-or-zero grant; a transfer happens when req_valid[i]&&req_ready[i]
- cdb_out  out  cdb_t  registered CDB broadcast payload
- cdb_out_valid  out  1  registered broadcast valid

Behaviour:
- Reset (async, rst=1): cdb_out='0, cdb_out_valid=0, all wait_cnt=0. req_ready=0 while rst is high.
- Starved set: starved[i] = req_valid[i] && wait_cnt[i]==STARVE_LIMIT.
- Grant selection (combinational):
  - if flush or cdb_stall, no grant;
  - else if any starved[i], grant the lowest starved index;
  - else grant the lowest i with req_valid[i].
  - req_ready[g]=1 for the granted index only. req_ready never depends on req_data.
- Latency: a transfer in cycle N appears on cdb_out/cdb_out_valid in cycle N+1, for exactly one cycle.
- No transfer in cycle N: cdb_out='0 and cdb_out_valid=0 in N+1. Stale payloads are never held.
- Wait counters, per i, per cycle, evaluated in this order:
  - flush: clear to 0;
  - else !req_valid[i] or granted: clear to 0;
  - else cdb_stall: hold;
  - else increment, saturating at STARVE_LIMIT.
- Throughput: one transfer per cycle, back-to-back, with no bubble between grants.
- Simultaneous flush and cdb_stall: flush wins; counters clear.
- Flush:
  - no grant in the flush cycle;
  - the next cycle has cdb_out_valid=0, even if a transfer was pending registration;
  - a broadcast already on cdb_out during the flush cycle is not retracted.
- Requester dropping req_valid before grant is legal; its counter clears.
- Req_data must stay stable while req_valid is high and ungranted. This is a bench assertion, not enforced by the RTL.
- Reset mid-operation: all state clears immediately; an in-flight broadcast is lost.
- Bound: a continuously valid requester is granted within (NUM_REQ-1)*(STARVE_LIMIT+1)+STARVE_LIMIT+1 unstalled cycles.

Optional Feature:
- Macro CDB_ARB_PERF_EN.
- Defined: adds outputs perf_grant_cnt (32b × NUM_REQ, per-requester transfer count) and perf_starve_cnt (32b, counts cycles where the grant came from the starved path). Both counters wrap, are cleared by rst, and are not cleared by flush.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- types package holds:
  - cdb_t (existing);
  - NUM_CDB_REQ;
  - localparams CDB_REQ_BR=0, CDB_REQ_MEM=1, CDB_REQ_DIV=2, CDB_REQ_MUL=3, CDB_REQ_ALU=4;
  - CDB_STARVE_LIMIT default.
- One sub-module, cdb_wait_ctr: a single saturating counter with clear/hold/inc inputs and a sat output, instantiated NUM_REQ times via generate.
- Priority encoding stays in the top module.

Test Plan:
- Reset then idle: rst pulse mid-cycle → cdb_out_valid=0, req_ready=0 during reset, all counters 0; req_valid=5'b00000 for 10 cycles → cdb_out_valid stays 0.
- Fixed priority: req_valid=5'b10110 (mem, div, alu) with distinct tags → grants mem, div in consecutive cycles, then alu no later than the starvation cap. cdb_out carries each tag one cycle after its grant.
- Starvation: br and alu held valid continuously, br re-asserted every cycle, STARVE_LIMIT=8 → alu granted exactly after 8 waiting cycles (9th cycle), then br resumes.
- Stall: cdb_stall=1 for 5 cycles with alu waiting at wait_cnt=3 → req_ready=0, cdb_out_valid=0, wait_cnt stays 3. On release, the counter resumes at 4.
- Flush: grant to mul in cycle N, flush in cycle N → no transfer, cdb_out_valid=0 in N+1, all counters 0. Flush in N+1 after a grant in N → the N+1 broadcast stays visible.
- Perf (CDB_ARB_PERF_EN): 20 back-to-back grants forced through starvation 3 times → sum of perf_grant_cnt=20, perf_starve_cnt=3.

Source files
------------

// File: rtl/cdb_age_arbiter_pkg.sv
// rtl/cdb_age_arbiter_pkg.sv - shared CDB payload type and arbiter constants
//
// Purpose: holds the CDB payload struct, the requester count, the requester
//          index map and the default starvation limit used by the arbiter.
// Ports:   none (package)
package cdb_age_arbiter_pkg;

    // CDB broadcast payload: ROB tag plus result value.
    typedef struct packed {
        logic [5:0]  tag;
        logic [31:0] data;
    } cdb_t;

    localparam int NUM_CDB_REQ = 5;

    // Requester indices; a lower index has a higher base priority.
    localparam int CDB_REQ_BR  = 0;
    localparam int CDB_REQ_MEM = 1;
    localparam int CDB_REQ_DIV = 2;
    localparam int CDB_REQ_MUL = 3;
    localparam int CDB_REQ_ALU = 4;

    localparam int CDB_STARVE_LIMIT = 8;

endpackage

// File: rtl/cdb_wait_ctr.sv
// rtl/cdb_wait_ctr.sv - saturating per-requester wait counter
//
// Purpose: counts the cycles a requester has waited ungranted; saturates at LIMIT.
//          Priority of controls: clear > hold > inc.
// Ports:
//   clk, rst  clock, asynchronous active-high reset
//   clear     return the count to zero
//   hold      keep the current count
//   inc       advance the count by one, stopping at LIMIT
//   sat       count has reached LIMIT
module cdb_wait_ctr #(
    parameter int LIMIT = 8,
    parameter int CNT_W = $clog2(LIMIT + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic hold,
    input  logic inc,
    output logic sat
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (clear) begin
            r_cnt <= '0;
        end else if (hold) begin
            r_cnt <= r_cnt;
        end else if (inc && (r_cnt != CNT_W'(LIMIT))) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign sat = (r_cnt == CNT_W'(LIMIT));

endmodule

// File: rtl/cdb_age_arbiter.sv
// rtl/cdb_age_arbiter.sv - fixed-priority CDB arbiter with starvation promotion
//
// Purpose: grants one CDB writeback slot per cycle among NUM_REQ functional
//          units (0=br, 1=mem, 2=div, 3=mul, 4=alu). Lowest index wins, except
//          that any requester whose wait counter has saturated is served first.
//          The granted payload is registered onto the CDB for one cycle.
// Optional feature: macro CDB_ARB_PERF_EN adds perf_grant_cnt / perf_starve_cnt.
// Ports:
//   clk, rst         clock, asynchronous active-high reset
//   flush            synchronous pipeline flush (no grant, counters cleared)
//   cdb_stall        consumer backpressure (no grant, counters held)
//   req_valid/data   per-requester result handshake and payload
//   req_ready        one-hot-or-zero grant
//   cdb_out(_valid)  registered broadcast
//   perf_grant_cnt   per-requester transfer count    (CDB_ARB_PERF_EN only)
//   perf_starve_cnt  grants taken from starved path  (CDB_ARB_PERF_EN only)
module cdb_age_arbiter
    import cdb_age_arbiter_pkg::*;
#(
    parameter int NUM_REQ      = NUM_CDB_REQ,
    parameter int STARVE_LIMIT = CDB_STARVE_LIMIT,
    parameter int CNT_W        = $clog2(STARVE_LIMIT + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               cdb_stall,
    input  logic [NUM_REQ-1:0] req_valid,
    input  cdb_t               req_data [NUM_REQ],
    output logic [NUM_REQ-1:0] req_ready,
    output cdb_t               cdb_out,
    output logic               cdb_out_valid
`ifdef CDB_ARB_PERF_EN
    ,
    output logic [31:0]        perf_grant_cnt [NUM_REQ],
    output logic [31:0]        perf_starve_cnt
`endif
);

    logic [NUM_REQ-1:0] w_sat;
    logic [NUM_REQ-1:0] w_starved;
    logic [NUM_REQ-1:0] w_pick;
    logic               w_en;
    logic               w_xfer;
    cdb_t               w_payload;
    cdb_t               r_cdb_out;
    logic               r_cdb_out_valid;

    assign w_starved = req_valid & w_sat;
    assign w_en      = !rst && !flush && !cdb_stall;

    // Starved requesters shadow the normal ones; the lowest set bit of the
    // chosen set is the grant (x & -x isolates it).
    assign w_pick    = (|w_starved) ? w_starved : req_valid;
    assign req_ready = w_en ? (w_pick & (~w_pick + NUM_REQ'(1))) : '0;
    assign w_xfer    = |req_ready;

    always_comb begin
        w_payload = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req_ready[i]) begin
                w_payload = req_data[i];
            end
        end
    end

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_ctr
        cdb_wait_ctr #(
            .LIMIT (STARVE_LIMIT),
            .CNT_W (CNT_W)
        ) u_ctr (
            .clk   (clk),
            .rst   (rst),
            .clear (flush || !req_valid[gi] || req_ready[gi]),
            .hold  (cdb_stall),
            .inc   (req_valid[gi]),
            .sat   (w_sat[gi])
        );
    end

    // Payload is zeroed on idle cycles so a stale broadcast is never held.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cdb_out       <= '0;
            r_cdb_out_valid <= 1'b0;
        end else begin
            r_cdb_out       <= w_payload;
            r_cdb_out_valid <= w_xfer;
        end
    end

    assign cdb_out       = r_cdb_out;
    assign cdb_out_valid = r_cdb_out_valid;

`ifdef CDB_ARB_PERF_EN
    logic [31:0] r_perf_grant [NUM_REQ];
    logic [31:0] r_perf_starve;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                r_perf_grant[i] <= '0;
            end
            r_perf_starve <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (req_ready[i]) begin
                    r_perf_grant[i] <= r_perf_grant[i] + 32'd1;
                end
            end
            if (w_xfer && (|w_starved)) begin
                r_perf_starve <= r_perf_starve + 32'd1;
            end
        end
    end

    assign perf_grant_cnt  = r_perf_grant;
    assign perf_starve_cnt = r_perf_starve;
`endif

endmodule
